// File: rtl/edge_collector_pkg.sv
// edge_collector_pkg: state encoding and default widths for the edge collector
package edge_collector_pkg;
  typedef enum logic [1:0] {SCAN = 2'd0, WRITE = 2'd1, HOLD = 2'd2} state_t;
  localparam int TAGW_DEF = 8;
  localparam int WORD_W = 32;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search for the first set flag at or above ptr
module rr_pick #(
  parameter int NCH = 8,
  parameter int PW = $clog2(NCH)
) (
  input  logic [NCH-1:0] avail,
  input  logic [PW-1:0]  ptr,
  output logic           grant_valid,
  output logic [PW-1:0]  grant_idx
);
  logic [PW-1:0] j;
  always_comb begin
    grant_valid = |avail;
    grant_idx = '0;
    j = '0;
    // walk offsets downward so the nearest set flag from ptr is the last to win
    for (int i = NCH - 1; i >= 0; i--) begin
      j = PW'((int'(ptr) + i) % NCH);
      if (avail[j]) grant_idx = j;
    end
  end
endmodule

// File: rtl/edge_collector.sv
// edge_collector: round-robin drains edge_buffer captures into tagged FIFO words
module edge_collector
  import edge_collector_pkg::*;
#(
  parameter int NCH = 8,
  parameter int bitwidth = 24,
  parameter int TAGW = TAGW_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NCH-1:0]           avail,
  input  logic [NCH*bitwidth-1:0]  q,
  output logic [NCH-1:0]           clear,
  input  logic                     fifo_full,
  output logic [TAGW+bitwidth-1:0] fifo_data,
  output logic                     fifo_wr,
  output logic [31:0]              word_count,
  input  logic                     count_clear,
  output logic                     busy
);
  localparam int PW = $clog2(NCH);
  state_t state, state_nx;
  logic [PW-1:0] rr_ptr, ch, gidx;
  logic gvalid, grant;
  rr_pick #(.NCH(NCH), .PW(PW)) u_pick (
    .avail(avail),
    .ptr(rr_ptr),
    .grant_valid(gvalid),
    .grant_idx(gidx)
  );
  always_comb begin
    grant = state == SCAN && enable && !fifo_full && gvalid;
    state_nx = state == SCAN ? (grant ? WRITE : SCAN) : state == WRITE ? HOLD : SCAN;
    fifo_wr = state == WRITE;
    clear = fifo_wr ? NCH'(1) << ch : '0;
    busy = state != SCAN;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= SCAN;
      rr_ptr <= '0;
      ch <= '0;
      fifo_data <= '0;
      word_count <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        ch <= gidx;
        fifo_data <= {TAGW'(gidx), q[gidx*bitwidth +: bitwidth]};
      end
      if (state == HOLD) rr_ptr <= ch == PW'(NCH - 1) ? '0 : ch + 1'b1;
      word_count <= count_clear ? '0 : word_count + 32'(fifo_wr);
    end
  end
endmodule

// File: tb/tb_edge_collector.sv
// tb_edge_collector: directed stimulus with a scoreboard queue checked by a write monitor
module tb_edge_collector;
  logic clock, reset, enable, fifo_full, count_clear, fifo_wr, busy;
  logic [7:0] avail, clear, arm;
  logic flush;
  logic [8*24-1:0] q;
  logic [31:0] fifo_data, word_count;
  logic [31:0] sb[$];
  int compared = 0, mismatched = 0, wr_cnt = 0, cyc = 0, last_wr = 0;
  bit fair = 0, have_last = 0;

  edge_collector dut (
    .clock(clock), .reset(reset), .enable(enable), .avail(avail), .q(q),
    .clear(clear), .fifo_full(fifo_full), .fifo_data(fifo_data), .fifo_wr(fifo_wr),
    .word_count(word_count), .count_clear(count_clear), .busy(busy)
  );

  initial clock = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // edge_buffer bank model: flags set by arm, dropped by the synchronous clear
  always @(posedge clock) avail <= flush ? 8'h00 : (avail & ~clear) | arm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    logic [31:0] e;
    logic [7:0] ec;
    if (fifo_wr) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got %h expected no write (t=%0t)", fifo_data, $time);
      end else begin
        e = sb.pop_front();
        ec = 8'd1 << e[26:24];
        chk("fifo_data", fifo_data, e);
        chk("clear_wr", {24'd0, clear}, {24'd0, ec});
        if (fair && have_last) chk("spacing", cyc - last_wr, 3);
        last_wr = cyc;
        have_last = 1;
      end
      wr_cnt++;
    end else chk("clear_idle", {24'd0, clear}, 0);
  end

  task automatic do_reset();
    reset = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1;
  endtask

  task automatic pulse_arm(input logic [7:0] m);
    @(posedge clock);
    #1 arm = m;
    @(posedge clock);
    #1 arm = 8'h00;
  endtask

  task automatic wait_wr(input int target);
    int n = 0;
    while (wr_cnt < target && n < 200) begin
      @(posedge clock);
      #2 n++;
    end
    if (wr_cnt < target) chk("wait_timeout", wr_cnt, target);
  endtask

  task automatic poll_wr();
    int n = 0;
    do begin
      @(posedge clock);
      #1 n++;
    end while (!fifo_wr && n < 200);
    if (!fifo_wr) chk("poll_timeout", {31'd0, fifo_wr}, 1);
  endtask

  initial begin
    logic [31:0] fair_tab[9];
    fair_tab = '{32'h00C0FFE0, 32'h01C0FFE1, 32'h02ABCDEF, 32'h03C0FFE3, 32'h04C0FFE4,
                 32'h05C0FFE5, 32'h06C0FFE6, 32'h07C0FFE7, 32'h00C0FFE0};
    enable = 1; fifo_full = 0; count_clear = 0; arm = 0; flush = 1; reset = 1;
    for (int i = 0; i < 8; i++) q[i*24 +: 24] = 24'hC0FFE0 + 24'(i);
    q[2*24 +: 24] = 24'hABCDEF;
    #1 reset = 0;
    #1 chk("rst_fifo_wr", {31'd0, fifo_wr}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_data", fifo_data, 0);
    chk("rst_count", word_count, 0);
    do_reset();
    @(posedge clock);
    #1 flush = 0;
    // single channel
    sb.push_back(32'h02ABCDEF);
    pulse_arm(8'h04);
    wait_wr(1);
    chk("count_single", word_count, 1);
    // round-robin fairness with flags re-armed continuously
    do_reset();
    fair = 1; have_last = 0;
    for (int i = 0; i < 9; i++) sb.push_back(fair_tab[i]);
    @(posedge clock);
    #1 arm = 8'hFF;
    wait_wr(10);
    enable = 0; arm = 8'h00; fair = 0;
    chk("count_fair", word_count, 9);
    // enable low with every flag set: no grants
    repeat (10) @(posedge clock);
    #2 chk("idle_busy", {31'd0, busy}, 0);
    // enable dropped during WRITE still completes the word
    sb.push_back(32'h01C0FFE1);
    enable = 1;
    poll_wr();
    enable = 0;
    wait_wr(11);
    repeat (10) @(posedge clock);
    #2 chk("en_off_count", wr_cnt, 11);
    chk("en_off_avail", {24'd0, avail}, 32'h000000FD);
    // backpressure
    flush = 1;
    do_reset();
    #1 flush = 0; fifo_full = 1; enable = 1;
    pulse_arm(8'h01);
    repeat (20) @(posedge clock);
    #2 chk("bp_count", wr_cnt, 11);
    chk("bp_busy", {31'd0, busy}, 0);
    sb.push_back(32'h00C0FFE0);
    fifo_full = 0;
    wait_wr(12);
    repeat (6) @(posedge clock);
    #2 chk("bp_one_write", wr_cnt, 12);
    // counter clear colliding with the 6th write
    do_reset();
    for (int i = 0; i < 6; i++) sb.push_back({8'(i), 24'hC0FFE0 + 24'(i)});
    sb[2] = 32'h02ABCDEF;
    pulse_arm(8'h3F);
    wait_wr(17);
    chk("count_five", word_count, 5);
    poll_wr();
    count_clear = 1;
    @(posedge clock);
    #1 count_clear = 0;
    chk("count_cleared", word_count, 0);
    sb.push_back(32'h07C0FFE7);
    pulse_arm(8'h80);
    wait_wr(19);
    chk("count_resume", word_count, 1);
    // async reset in the middle of WRITE
    pulse_arm(8'h10);
    poll_wr();
    #1 reset = 0;
    #1 chk("ar_fifo_wr", {31'd0, fifo_wr}, 0);
    chk("ar_clear", {24'd0, clear}, 0);
    chk("ar_busy", {31'd0, busy}, 0);
    chk("ar_count", word_count, 0);
    @(posedge clock);
    #1 reset = 1;
    chk("ar_avail_kept", {24'd0, avail}, 32'h00000010);
    sb.push_back(32'h04C0FFE4);
    wait_wr(20);
    chk("ar_count_after", word_count, 1);
    repeat (5) @(posedge clock);
    #2 chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/edge_collector.md
Name: edge_collector

Overview:
- Downstream consumer of a bank of edge_buffer capture registers.
- Round-robin scans the avail flags and packs each captured value with its channel number into a 32-bit word.
- Writes each word into the timestamp FIFO, then pulses that channel's clear line, which drives the edge_buffer reset, to re-arm it.
- Sits between the per-channel capture stage and the host-readable FIFO.

Parameters:
- NCH, 8: number of edge_buffer channels served (2..16).
- bitwidth, 24: width of each captured value. Must equal the edge_buffer bitwidth.
- TAGW, 8: channel tag width in the output word. Output width is TAGW+bitwidth = 32.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = grant new channels; 0 = finish the current transfer, then idle.
- avail  in  NCH  avail flags from the edge_buffers, bit i = channel i.
- q  in  NCH*bitwidth  captured values; channel i occupies bits [i*bitwidth +: bitwidth].
- clear  out  NCH  one-cycle pulse to the edge_buffer reset of the serviced channel.
- fifo_full  in  1  FIFO cannot accept a write this cycle.
- fifo_data  out  TAGW+bitwidth  {channel number zero-extended to TAGW, captured value}.
- fifo_wr  out  1  one-cycle FIFO write strobe.
- word_count  out  32  words written since reset or count_clear. Wraps at 2^32.
- count_clear  in  1  synchronous clear of word_count.
- busy  out  1  high in any state other than SCAN.

Behaviour:
- Reset (reset=0, asynchronous): state=SCAN, rr_ptr=0, clear=0, fifo_wr=0, fifo_data=0, word_count=0, busy=0.
- SCAN:
  - Grants only when enable=1, fifo_full=0 and |avail.
  - Grant = first set avail bit searching from rr_ptr upward, wrapping modulo NCH.
  - On a grant: latch ch and {ch, q[ch]} into fifo_data; go to WRITE.
  - Otherwise stay in SCAN.
- WRITE: fifo_wr=1 and clear[ch]=1 for exactly this cycle; word_count increments; go to HOLD.
- HOLD:
  - One cycle that lets the synchronous edge_buffer reset drop avail[ch], so a stale flag is never re-granted.
  - rr_ptr <= (ch+1) mod NCH; go to SCAN.
- Timing:
  - Latency: avail rising (seen in SCAN) -> fifo_wr in the next cycle.
  - Peak throughput: one word per 3 cycles.
- fifo_data holds its value until the next grant. Only fifo_wr qualifies it.
- fifo_full is sampled only in SCAN. A grant committed in SCAN completes even if fifo_full rises during WRITE; the FIFO must have one word of slack (the almost-full convention).
- enable dropping during WRITE or HOLD does not abort the transfer; it only blocks the next grant.
- Only one clear bit is ever high; clear is never asserted outside WRITE.
- count_clear wins over a simultaneous increment, so word_count=0 the next cycle.
- Channel tag: ch zero-extended into bits [TAGW+bitwidth-1 : bitwidth].
- Reset mid-transfer: all outputs return to reset values immediately. A channel latched but not yet cleared stays avail and is serviced after reset.

Decomposition:
- Package edge_collector_pkg:
  - state encoding SCAN=2'd0, WRITE=2'd1, HOLD=2'd2;
  - constants for the default TAGW and output word width.
- Sub-module rr_pick:
  - combinational round-robin priority search over avail starting at rr_ptr;
  - outputs grant_valid and grant_idx.
  - Parameterised by NCH; reusable by other multi-channel collectors.

Test Plan:
- Single channel: after reset, avail=8'h04, q[2]=24'hABCDEF -> fifo_wr one cycle later with fifo_data=32'h02ABCDEF; clear=8'h04 the same cycle; word_count=1.
- Round-robin fairness: avail=8'hFF held and re-set immediately after each clear -> tags appear in order 0,1,...,7,0; every fifo_wr is spaced exactly 3 cycles apart.
- Backpressure: fifo_full=1 with avail=8'h01 -> no fifo_wr and no clear for 20 cycles; release fifo_full -> exactly one write of channel 0.
- enable=0 asserted during WRITE -> the current word completes (fifo_wr=1, clear pulses); no further grants while enable=0, even with avail=8'hFF.
- Counter: write 5 words, then count_clear in the same cycle as a 6th WRITE -> word_count=0 next cycle; increments resume from 0 on the next word.
- Async reset: drop reset mid-WRITE -> fifo_wr, clear and busy go 0 without waiting for a clock edge; the still-avail channel is re-serviced after reset releases.
